programmer_master: RTL and testbench

- SPI mode-00 initiator that drives the chip programming interface (SDI, SCLK, CS) from the on-chip control logic or test harness.
- Serialises one NUM_BITS configuration word LSB-first, then raises CS so the programmer latches the word.
- Also issues a digital-reset pulse: CS high with SCLK high asserts DRESET at the target.
- All outputs are registered, with one clock domain.

---
 rtl/programmer_pkg.sv | 65 ++++++
 rtl/programmer_master_if.sv | 18 +
 rtl/programmer_tick_gen.sv | 22 ++
 rtl/programmer_master.sv | 123 ++++++++++++
 tb/tb_programmer_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/programmer_pkg.sv
// Shared definitions for the chip programming-interface initiator:
// word length, programmer field map and controller states.
package programmer_pkg;

   localparam int unsigned NUM_BITS = 111;

   // Field map of the configuration word (LSB position / width)
   localparam int unsigned GTHDR_LSB      = 0;
   localparam int unsigned GTHDR_W        = 5;
   localparam int unsigned GTHSNR_LSB     = 5;
   localparam int unsigned GTHSNR_W       = 5;
   localparam int unsigned FCHSNR_LSB     = 10;
   localparam int unsigned FCHSNR_W       = 4;
   localparam int unsigned HSNR_EN_BIT    = 14;
   localparam int unsigned HDR_EN_BIT     = 15;
   localparam int unsigned BG_PROG_EN_BIT = 16;
   localparam int unsigned BG_PROG_LSB    = 17;
   localparam int unsigned BG_PROG_W      = 4;
   localparam int unsigned LDO_LSB        = 21;
   localparam int unsigned LDO_W          = 6;
   localparam int unsigned HPFEN_BIT      = 27;
   localparam int unsigned OGPH_LSB       = 28;
   localparam int unsigned OGPH_W         = 24;
   localparam int unsigned OGPN_LSB       = 52;
   localparam int unsigned OGPN_W         = 24;
   localparam int unsigned ATHHI_LSB      = 76;
   localparam int unsigned ATHHI_W        = 9;
   localparam int unsigned ATHLO_LSB      = 85;
   localparam int unsigned ATHLO_W        = 9;
   localparam int unsigned ATO_LSB        = 94;
   localparam int unsigned ATO_W          = 5;
   localparam int unsigned REF_OUT_BIT    = 99;
   localparam int unsigned DLL_LSB        = 100;
   localparam int unsigned DLL_W          = 4;
   localparam int unsigned DLLDAC_LSB     = 104;
   localparam int unsigned DLLDAC_W       = 5;
   localparam int unsigned CLKOUTSEL_BIT  = 109;
   localparam int unsigned OP_MODE_BIT    = 110;

   // Same map as a packed payload, MSB field first
   typedef struct packed {
      logic        op_mode;
      logic        clkoutsel;
      logic [4:0]  dlldac;
      logic [3:0]  dll;
      logic        ref_out;
      logic [4:0]  ato;
      logic [8:0]  athlo;
      logic [8:0]  athhi;
      logic [23:0] ogpn;
      logic [23:0] ogph;
      logic        hpfen;
      logic [5:0]  ldo;
      logic [3:0]  bg_prog;
      logic        bg_prog_en;
      logic        hdr_en;
      logic        hsnr_en;
      logic [3:0]  fchsnr;
      logic [4:0]  gthsnr;
      logic [4:0]  gthdr;
   } prog_word_t;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP, DRST} state_t;

endpackage

// File: rtl/programmer_master_if.sv
// Request/status handshake plus the three-wire programming bus.
interface programmer_master_if #(
   parameter int unsigned NUM_BITS = programmer_pkg::NUM_BITS
);
   logic                start;
   logic [NUM_BITS-1:0] data_in;
   logic                dreset_req;
   logic                busy;
   logic                done;
   logic                SDI;
   logic                SCLK;
   logic                CS;

   modport master (input start, data_in, dreset_req,
                   output busy, done, SDI, SCLK, CS);
   modport slave  (output start, data_in, dreset_req,
                   input busy, done, SDI, SCLK, CS);
endinterface

// File: rtl/programmer_tick_gen.sv
// Loadable half-period down-counter; tick_c marks the last cycle of a period.
module programmer_tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tick_c
);
   localparam int unsigned CW = $clog2(DIV + 1);

   logic [CW-1:0] cnt;

   // Saturates at zero so an unreloaded counter never wraps
   always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (load)         cnt <= CW'(DIV);
      else if (cnt != '0)    cnt <= cnt - CW'(1);
   end

   assign tick_c = (cnt == CW'(1));
endmodule

// File: rtl/programmer_master.sv
// SPI mode-0 initiator: shifts one configuration word LSB-first and commits it
// with a CS rising edge, or drives a CS-high/SCLK-high digital-reset pulse.
module programmer_master #(
   parameter int unsigned NUM_BITS    = programmer_pkg::NUM_BITS,
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned DRST_CYCLES = 16
) (
   input logic                 CLK,
   input logic                 RST,
   programmer_master_if.master bus
);
   import programmer_pkg::*;

   localparam int unsigned BW = $clog2(NUM_BITS + 1);
   localparam int unsigned RW = $clog2(DRST_CYCLES + 1);

   state_t              state, state_n;
   logic [NUM_BITS-1:0] shreg, shreg_n;
   logic [BW-1:0]       bit_cnt, bit_cnt_n;
   logic [RW-1:0]       drst_cnt, drst_cnt_n;
   logic                tick_c, load_c;
   logic                cs_q, sclk_q, sdi_q, busy_q, done_q;
   logic                cs_n, sclk_n, sdi_n, busy_n, done_n;

   programmer_tick_gen #(.DIV(CLK_DIV)) u_tick (
      .clk    (CLK),
      .rst    (RST),
      .load   (load_c),
      .tick_c (tick_c)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         drst_cnt <= '0;
         cs_q     <= 1'b1;
         sclk_q   <= 1'b0;
         sdi_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         drst_cnt <= drst_cnt_n;
         cs_q     <= cs_n;
         sclk_q   <= sclk_n;
         sdi_q    <= sdi_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      drst_cnt_n = drst_cnt;
      load_c     = 1'b0;
      done_n     = 1'b0;

      case (state)
         IDLE: begin
            // Digital reset has priority over a simultaneous frame request
            if (bus.dreset_req) begin
               state_n    = DRST;
               drst_cnt_n = RW'(DRST_CYCLES);
            end else if (bus.start) begin
               state_n   = SETUP;
               shreg_n   = bus.data_in;
               bit_cnt_n = '0;
            end
         end
         SETUP: if (tick_c) state_n = HIGH;
         HIGH: begin
            if (tick_c) begin
               bit_cnt_n = bit_cnt + BW'(1);
               if (bit_cnt_n == BW'(NUM_BITS)) begin
                  state_n = HOLD;
               end else begin
                  state_n = LOW;
                  shreg_n = shreg >> 1;
               end
            end
         end
         LOW:  if (tick_c) state_n = HIGH;
         HOLD: if (tick_c) state_n = GAP;
         GAP: begin
            if (tick_c) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         DRST: begin
            // SCLK-high phase counted here, then one divider period low
            if (drst_cnt != '0) begin
               drst_cnt_n = drst_cnt - RW'(1);
               load_c     = (drst_cnt_n == '0);
            end else if (tick_c) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n != state) load_c = 1'b1;

      // Outputs follow the state being entered so they stay registered
      busy_n = (state_n != IDLE);
      cs_n   = !(state_n inside {SETUP, HIGH, LOW, HOLD});
      sclk_n = (state_n == HIGH) || ((state_n == DRST) && (drst_cnt_n != '0));
      sdi_n  = (state_n inside {SETUP, HIGH, LOW}) ? shreg_n[0] : 1'b0;
   end

   assign bus.CS   = cs_q;
   assign bus.SCLK = sclk_q;
   assign bus.SDI  = sdi_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_programmer_master.sv
// Scoreboard bench: a behavioural target decodes the serial bus and each done
// pulse is checked against the request queued when it was issued.
module tb_programmer_master;
   import programmer_pkg::*;

   localparam int unsigned N  = NUM_BITS;
   localparam int unsigned D  = 4;
   localparam int unsigned DR = 16;

   typedef struct {
      bit          is_drst;
      logic [N-1:0] word;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   programmer_master_if #(.NUM_BITS(N)) bus ();
   programmer_master_if #(.NUM_BITS(N)) bus1 ();

   programmer_master #(.NUM_BITS(N), .CLK_DIV(D), .DRST_CYCLES(DR)) u_dut (
      .CLK(CLK), .RST(RST), .bus(bus));
   programmer_master #(.NUM_BITS(N), .CLK_DIV(1), .DRST_CYCLES(3)) u_dut1 (
      .CLK(CLK), .RST(RST), .bus(bus1));

   int checks = 0, failures = 0;
   exp_t exp_q[$];
   logic [N-1:0] committed = '0;
   int n_acc = 0, done_cnt = 0;

   // Target-side view of the bus for the main instance
   logic [N-1:0] tgt_sh = '0, tgt_prog = '0;
   logic p_cs = 1'b1, p_sclk = 1'b0, p_sdi = 1'b0;
   int cyc = 0, rises = 0, cs_low = 0, dr_low = 0, dr_first = 0, fall_cyc = 0;
   int viol = 0, sdi_age = 1000;

   // Target-side view for the CLK_DIV=1 instance
   logic [N-1:0] sh1 = '0, prog1 = '0, exp1 = '0;
   logic p1_cs = 1'b1, p1_sclk = 1'b0;
   int cs1_low = 0, d1_done = 0;

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic check_w(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [N-1:0] rand_word();
      logic [N-1:0] w = '0;
      for (int i = 0; i < N; i += 32) w = (w << 32) | N'($urandom);
      return w;
   endfunction

   function automatic logic [N-1:0] a5_word();
      logic [7:0]   b = 8'hA5;
      logic [N-1:0] w = '0;
      for (int i = 0; i < N; i++) w[i] = b[i % 8];
      return w;
   endfunction

   // Monitor: decode the bus like the programmer would and score each done
   always @(negedge CLK) begin
      exp_t       e;
      prog_word_t pw;
      cyc++;
      if (bus.SDI !== p_sdi) begin
         sdi_age = 0;
         if (bus.SCLK === 1'b1) viol++;
      end else begin
         sdi_age++;
      end
      if (bus.CS === 1'b1 && bus.SDI === 1'b1) viol++;
      if (bus.CS === 1'b0 && bus.SCLK === 1'b1 && p_sclk === 1'b0) begin
         tgt_sh = {bus.SDI, tgt_sh[N-1:1]};
         rises++;
         if (sdi_age < int'(D)) viol++;
      end
      if (bus.CS === 1'b1 && p_cs === 1'b0) tgt_prog = tgt_sh;
      if (bus.CS === 1'b0 && p_cs === 1'b1) fall_cyc = cyc;
      if (bus.CS === 1'b0) cs_low++;
      if (bus.CS === 1'b1 && bus.SCLK === 1'b1) begin
         if (dr_low == 0) dr_first = cyc;
         dr_low++;
      end
      if (bus.done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check_int("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_int("busy_at_done", int'(bus.busy), 0);
            if (e.is_drst) begin
               check_int("drst_sclk_high_cycles", dr_low, int'(DR));
               check_int("drst_cs_low_cycles", cs_low, 0);
               check_int("drst_done_latency", cyc - dr_first, int'(DR + D));
               check_w("drst_prog_kept", tgt_prog, e.word);
            end else begin
               pw = tgt_prog;
               check_w("frame_word", tgt_prog, e.word);
               check_int("frame_ogph", int'(pw.ogph), int'((e.word >> OGPH_LSB) & N'(24'hFFFFFF)));
               check_int("frame_sclk_rises", rises, int'(N));
               check_int("frame_cs_low_cycles", cs_low, int'((2 * N + 1) * D));
               check_int("frame_done_latency", cyc - fall_cyc, int'((2 * N + 2) * D));
               check_int("frame_no_dreset", dr_low, 0);
            end
            check_int("bus_invariants", viol, 0);
         end
         rises = 0; cs_low = 0; dr_low = 0; viol = 0;
      end
      if (RST === 1'b1) begin
         rises = 0; cs_low = 0; dr_low = 0; viol = 0;
      end
      p_cs = bus.CS; p_sclk = bus.SCLK; p_sdi = bus.SDI;
   end

   always @(negedge CLK) begin
      if (bus1.CS === 1'b0 && bus1.SCLK === 1'b1 && p1_sclk === 1'b0) sh1 = {bus1.SDI, sh1[N-1:1]};
      if (bus1.CS === 1'b1 && p1_cs === 1'b0) prog1 = sh1;
      if (bus1.CS === 1'b0) cs1_low++;
      if (bus1.done === 1'b1) begin
         check_w("div1_word", prog1, exp1);
         check_int("div1_cs_low_cycles", cs1_low, int'(2 * N + 1));
         d1_done++;
         cs1_low = 0;
      end
      p1_cs = bus1.CS; p1_sclk = bus1.SCLK;
   end

   task automatic request(input bit s, input bit d, input logic [N-1:0] w, input bit accepted);
      @(posedge CLK); #1;
      bus.start = s; bus.dreset_req = d; bus.data_in = w;
      if (accepted) begin
         n_acc++;
         if (d) exp_q.push_back('{1'b1, committed});
         else begin
            exp_q.push_back('{1'b0, w});
            committed = w;
         end
      end
      @(posedge CLK); #1;
      bus.start = 1'b0; bus.dreset_req = 1'b0; bus.data_in = rand_word();
      if (accepted) begin
         @(negedge CLK);
         check_int("busy_after_request", int'(bus.busy), 1);
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (bus.done !== 1'b1 && n < budget);
      if (bus.done !== 1'b1) check_int("done_timeout", 0, 1);
   endtask

   initial begin
      logic [N-1:0] w;
      int n, dc;
      bus.start = 1'b0; bus.dreset_req = 1'b0; bus.data_in = '0;
      bus1.start = 1'b0; bus1.dreset_req = 1'b0; bus1.data_in = '0;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_int("rst_cs", int'(bus.CS), 1);
      check_int("rst_sclk", int'(bus.SCLK), 0);
      check_int("rst_sdi", int'(bus.SDI), 0);
      check_int("rst_busy", int'(bus.busy), 0);
      check_int("rst_done", int'(bus.done), 0);
      @(posedge CLK); #1 RST = 1'b0;

      request(1'b1, 1'b0, a5_word(), 1'b1); wait_done(2000);
      request(1'b1, 1'b0, '1, 1'b1);        wait_done(2000);
      request(1'b0, 1'b1, '0, 1'b1);        wait_done(200);
      request(1'b1, 1'b1, rand_word(), 1'b1); wait_done(200);

      // Requests during a frame must be dropped
      w = rand_word();
      request(1'b1, 1'b0, w, 1'b1);
      repeat (100) @(posedge CLK);
      request(1'b1, 1'b0, ~w, 1'b0);
      repeat (50) @(posedge CLK);
      request(1'b0, 1'b1, '0, 1'b0);
      wait_done(2000);

      repeat (5) begin
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         if ($urandom_range(0, 3) == 0) request(1'b0, 1'b1, '0, 1'b1);
         else request(1'b1, 1'b0, rand_word(), 1'b1);
         wait_done(2000);
      end

      // Abort a frame around bit 50
      request(1'b1, 1'b0, rand_word(), 1'b1);
      n = 0;
      while (rises < 50 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      check_int("reached_bit50", int'(rises >= 50), 1);
      exp_q.delete();
      n_acc--;
      dc = done_cnt;
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check_int("abort_cs", int'(bus.CS), 1);
      check_int("abort_sclk", int'(bus.SCLK), 0);
      check_int("abort_sdi", int'(bus.SDI), 0);
      check_int("abort_busy", int'(bus.busy), 0);
      repeat (1000) @(negedge CLK);
      check_int("abort_no_done", done_cnt, dc);
      request(1'b1, 1'b0, rand_word(), 1'b1); wait_done(2000);

      // Single-cycle half-period instance
      w = rand_word();
      exp1 = w;
      @(posedge CLK); #1 bus1.start = 1'b1; bus1.data_in = w;
      @(posedge CLK); #1 bus1.start = 1'b0; bus1.data_in = ~w;
      n = 0;
      while (d1_done == 0 && n < 1000) begin
         @(negedge CLK);
         n++;
      end

      repeat (1000) @(negedge CLK);
      check_int("queue_empty", exp_q.size(), 0);
      check_int("done_count", done_cnt, n_acc);
      check_int("div1_done_count", d1_done, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
